// File: rtl/mem_arbiter_if.sv
// Bundle of the icache port (p0), dcache port (p1) and main-memory port seen by mem_arbiter.
// Handshake: a requester holds read/write high and waits while busywait is high; the cycle
// busywait is low with the request still high, readdata is valid and the access has completed.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              p0_read;
  logic [ADDR_W-1:0] p0_address;
  logic [DATA_W-1:0] p0_readdata;
  logic              p0_busywait;

  logic              p1_read;
  logic              p1_write;
  logic [ADDR_W-1:0] p1_address;
  logic [DATA_W-1:0] p1_writedata;
  logic [DATA_W-1:0] p1_readdata;
  logic              p1_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  p0_read, p0_address,
    output p0_readdata, p0_busywait,
    input  p1_read, p1_write, p1_address, p1_writedata,
    output p1_readdata, p1_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output p0_read, p0_address,
    input  p0_readdata, p0_busywait,
    output p1_read, p1_write, p1_address, p1_writedata,
    input  p1_readdata, p1_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing main memory between the icache (p0, read-only) and the
// dcache (p1, read/write); address, write data and operation are latched at grant.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [0:0]    fsm_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state;
  logic              gnt;
  logic              last_grant;
  logic              op_write;
  logic              done0;
  logic              done1;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic req0, req1, avail0, avail1, pick, start;

  // A port is masked during its own done cycle so a held request cannot re-win immediately.
  always_comb begin
    req0   = bus.p0_read;
    req1   = bus.p1_read | bus.p1_write;
    avail0 = req0 & ~done0;
    avail1 = req1 & ~done1;
    pick   = (avail0 & avail1) ? ~last_grant : avail1;
    start  = (state == IDLE) & (avail0 | avail1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      op_write   <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= BUSY;
            gnt        <= pick;
            last_grant <= pick;
            addr_q     <= pick ? bus.p1_address : bus.p0_address;
            op_write   <= pick & bus.p1_write;
            if (pick & bus.p1_write) wdata_q <= bus.p1_writedata;
          end
        end
        BUSY: begin
          if (!bus.mem_busywait) begin
            if (!op_write) begin
              if (gnt) rdata1_q <= bus.mem_readdata;
              else     rdata0_q <= bus.mem_readdata;
            end
            if (gnt) done1 <= 1'b1;
            else     done0 <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read      = (state == BUSY) & ~op_write;
  assign bus.mem_write     = (state == BUSY) & op_write;
  assign bus.mem_address   = addr_q;
  assign bus.mem_writedata = wdata_q;
  assign bus.p0_readdata   = rdata0_q;
  assign bus.p1_readdata   = rdata1_q;
  assign bus.p0_busywait   = req0 & ~done0;
  assign bus.p1_busywait   = req1 & ~done1;
  assign fsm_state         = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a latency-programmable memory
// and a transaction-level reference of memory contents and round-robin order.
module tb_mem_arbiter;

  localparam logic [0:0] ST_IDLE = 1'b0;

  logic       clk;
  logic       reset;
  logic [0:0] fsm_state;

  mem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  int          lat = 1;
  int          cnt;
  logic [31:0] mem_arr [64];
  logic [63:0] wr_valid = '0;
  logic        ovr_en;
  logic [5:0]  ovr_addr;
  logic [31:0] ovr_data;

  function automatic logic [31:0] pattern(input logic [5:0] a);
    return 32'h9E3779B9 * ({26'd0, a} + 32'd1);
  endfunction

  assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (cnt < lat - 1);

  always_comb begin
    if (ovr_en && bus.mem_address == ovr_addr) bus.mem_readdata = ovr_data;
    else if (wr_valid[bus.mem_address])        bus.mem_readdata = mem_arr[bus.mem_address];
    else                                       bus.mem_readdata = pattern(bus.mem_address);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 0;
    end else begin
      if ((bus.mem_read | bus.mem_write) && bus.mem_busywait) cnt <= cnt + 1;
      else cnt <= 0;
      if (bus.mem_write && !bus.mem_busywait) begin
        mem_arr[bus.mem_address]  <= bus.mem_writedata;
        wr_valid[bus.mem_address] <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard / reference ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] exp_q[$];
  bit          model_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p0_read      = 1'b0;
    bus.p0_address   = '0;
    bus.p1_read      = 1'b0;
    bus.p1_write     = 1'b0;
    bus.p1_address   = '0;
    bus.p1_writedata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_port(input bit port, output int n);
    n = 0;
    while ((port ? bus.p1_busywait : bus.p0_busywait) && n < 60) begin
      tick();
      n++;
    end
    check("wait_timeout", 32'(n < 60), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, strobes;
    bit addr_ok, wr_seen, p1_hold, prev_strobe;
    logic [31:0] saved;
    int starts, idle_n, mode;
    bit use0, use1, w1, pend0, pend1, first_seen, exp_first;
    logic [5:0] a0, a1;
    logic [31:0] d1;

    for (int i = 0; i < 64; i++) ref_mem[i] = pattern(6'(i));
    ovr_en   = 1'b1;
    ovr_addr = 6'h05;
    ovr_data = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    idle_inputs();
    reset = 1'b1;
    tick();
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    check("rst_mem_wdata", bus.mem_writedata, 32'd0);
    check("rst_p0_rdata", bus.p0_readdata, 32'd0);
    check("rst_p1_rdata", bus.p1_readdata, 32'd0);
    check("rst_busywaits", {30'd0, bus.p0_busywait, bus.p1_busywait}, 32'd0);
    reset = 1'b0;
    tick();

    // T1: lone p0 read, latency 5
    lat = 5;
    bus.p0_read = 1'b1;
    bus.p0_address = 6'h05;
    #1;
    check("t1_bw_rise", 32'(bus.p0_busywait), 32'd1);
    strobes = 0; n = 0; addr_ok = 1'b1; wr_seen = 1'b0;
    do begin
      tick();
      n++;
      if (bus.mem_read) begin
        strobes++;
        if (bus.mem_address !== 6'h05) addr_ok = 1'b0;
      end
      if (bus.mem_write) wr_seen = 1'b1;
    end while (bus.p0_busywait && n < 40);
    check("t1_strobe_cycles", 32'(strobes), 32'd5);
    check("t1_addr", 32'(addr_ok), 32'd1);
    check("t1_no_write", 32'(wr_seen), 32'd0);
    check("t1_latency", 32'(n), 32'd6);
    check("t1_rdata", bus.p0_readdata, 32'hDEADBEEF);
    bus.p0_read = 1'b0;
    ovr_en = 1'b0;
    ref_mem[5] = pattern(6'h05);
    tick();

    // T2: simultaneous requests after reset, p0 wins the first tie
    do_reset();
    lat = 3;
    bus.p0_read = 1'b1; bus.p0_address = 6'h01;
    bus.p1_read = 1'b1; bus.p1_address = 6'h02;
    tick();
    check("t2_first_strobe", 32'(bus.mem_read), 32'd1);
    check("t2_first_addr", 32'(bus.mem_address), 32'h01);
    p1_hold = 1'b1; n = 0;
    if (!bus.p1_busywait) p1_hold = 1'b0;
    while (bus.p0_busywait && n < 60) begin
      tick();
      n++;
      if (!bus.p1_busywait) p1_hold = 1'b0;
    end
    check("t2_p1_stall", 32'(p1_hold), 32'd1);
    check("t2_gap", 32'(bus.mem_read), 32'd0);
    check("t2_p0_rdata", bus.p0_readdata, ref_mem[1]);
    bus.p0_read = 1'b0;
    tick();
    check("t2_second_strobe", 32'(bus.mem_read), 32'd1);
    check("t2_second_addr", 32'(bus.mem_address), 32'h02);
    wait_port(1'b1, n);
    check("t2_p1_rdata", bus.p1_readdata, ref_mem[2]);
    idle_inputs();
    tick();

    // T3: both ports continuously requesting alternate
    do_reset();
    lat = 2;
    exp_q = {32'h0A, 32'h0B, 32'h0A, 32'h0B};
    bus.p0_read = 1'b1; bus.p0_address = 6'h0A;
    bus.p1_read = 1'b1; bus.p1_address = 6'h0B;
    starts = 0; n = 0; prev_strobe = 1'b0;
    while (starts < 4 && n < 80) begin
      tick();
      n++;
      if (bus.mem_read && !prev_strobe) begin
        check("t3_rr_order", 32'(bus.mem_address), exp_q.pop_front());
        starts++;
      end
      prev_strobe = bus.mem_read;
    end
    check("t3_grant_count", 32'(starts), 32'd4);
    idle_inputs();
    n = 0;
    while (bus.mem_read && n < 20) begin tick(); n++; end
    tick();

    // T4: p1 write with write data changed after grant
    lat = 3;
    saved = bus.p1_readdata;
    bus.p1_write = 1'b1; bus.p1_address = 6'h3F; bus.p1_writedata = 32'h11223344;
    tick();
    check("t4_mem_write", {30'd0, bus.mem_read, bus.mem_write}, 32'd1);
    check("t4_addr", 32'(bus.mem_address), 32'h3F);
    check("t4_wdata", bus.mem_writedata, 32'h11223344);
    bus.p1_writedata = 32'h0;
    wait_port(1'b1, n);
    check("t4_mem_content", wr_valid[63] ? mem_arr[63] : 32'hX, 32'h11223344);
    check("t4_p1_rdata_kept", bus.p1_readdata, saved);
    ref_mem[63] = 32'h11223344;
    idle_inputs();
    tick();

    // T5: reset in the middle of a p1 read
    lat = 5;
    bus.p1_read = 1'b1; bus.p1_address = 6'h07;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t5_state", 32'(fsm_state), 32'(ST_IDLE));
    check("t5_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("t5_rdata", bus.p0_readdata | bus.p1_readdata, 32'd0);
    check("t5_bw_held", 32'(bus.p1_busywait), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check("t5_regrant", 32'(bus.mem_read), 32'd1);
    check("t5_regrant_addr", 32'(bus.mem_address), 32'h07);
    wait_port(1'b1, n);
    check("t5_p1_rdata", bus.p1_readdata, ref_mem[7]);
    idle_inputs();
    tick();

    // T6: p1 holds its request one cycle into done while p0 is pending
    lat = 2;
    bus.p1_read = 1'b1; bus.p1_address = 6'h10;
    tick();
    bus.p0_read = 1'b1; bus.p0_address = 6'h11;
    wait_port(1'b1, n);
    check("t6_p0_pending", 32'(bus.p0_busywait), 32'd1);
    check("t6_p1_rdata", bus.p1_readdata, ref_mem[16]);
    tick();
    check("t6_p0_grant", 32'(bus.mem_read), 32'd1);
    check("t6_p0_addr", 32'(bus.mem_address), 32'h11);
    check("t6_p1_bw_after_done", 32'(bus.p1_busywait), 32'd1);
    bus.p1_read = 1'b0;
    wait_port(1'b0, n);
    check("t6_p0_rdata", bus.p0_readdata, ref_mem[17]);
    bus.p0_read = 1'b0;
    tick();
    tick();
    check("t6_no_dup", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);

    // Randomized phase against the reference memory and round-robin model
    do_reset();
    model_last = 1'b1;
    for (int it = 0; it < 40; it++) begin
      lat  = $urandom_range(1, 4);
      mode = $urandom_range(1, 3);
      use0 = (mode != 2);
      use1 = (mode != 1);
      a0   = 6'($urandom_range(0, 63));
      a1   = 6'($urandom_range(0, 63));
      w1   = use1 && ($urandom_range(0, 2) == 0);
      d1   = $urandom;
      saved = bus.p1_readdata;
      bus.p0_read      = use0;
      bus.p0_address   = a0;
      bus.p1_write     = w1;
      bus.p1_read      = use1 && (!w1 || ($urandom_range(0, 1) == 1));
      bus.p1_address   = a1;
      bus.p1_writedata = d1;
      exp_first  = (use0 && use1) ? ~model_last : use1;
      pend0 = use0; pend1 = use1; first_seen = 1'b0; n = 0;
      while ((pend0 || pend1) && n < 100) begin
        tick();
        n++;
        if (pend0 && !bus.p0_busywait) begin
          if (!first_seen) check("rand_first_port", 32'd0, 32'(exp_first));
          first_seen = 1'b1;
          check("rand_p0_rdata", bus.p0_readdata, ref_mem[a0]);
          bus.p0_read = 1'b0;
          pend0 = 1'b0;
          model_last = 1'b0;
        end
        if (pend1 && !bus.p1_busywait) begin
          if (!first_seen) check("rand_first_port", 32'd1, 32'(exp_first));
          first_seen = 1'b1;
          if (w1) begin
            check("rand_p1_rdata_kept", bus.p1_readdata, saved);
            ref_mem[a1] = d1;
          end else begin
            check("rand_p1_rdata", bus.p1_readdata, ref_mem[a1]);
          end
          bus.p1_read  = 1'b0;
          bus.p1_write = 1'b0;
          pend1 = 1'b0;
          model_last = 1'b1;
        end
      end
      check("rand_timeout", 32'(n < 100), 32'd1);
      idle_n = $urandom_range(1, 3);
      for (int k = 0; k < idle_n; k++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
